// File: rtl/clk_reset_seq.sv
// Power-on reset sequencer: filters MMCM lock, holds peripherals in reset,
// then staggers the core reset release and tracks lock losses seen in RUN.
`timescale 1ns/1ps

module clk_reset_seq #(
    parameter int LOCK_FILTER = 16,
    parameter int HOLD_CYCLES = 256,
    parameter int CORE_DELAY  = 32
) (
    input  logic       sys_clock,
    input  logic       reset,
    input  logic       locked,
    input  logic       soft_reset_req,
    input  logic       lock_lost_clr,
    output logic       periph_reset,
    output logic       core_resetn,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] lock_loss_count
);

    localparam int MAX_AB = (LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES;
    localparam int MAX_P  = (MAX_AB > CORE_DELAY) ? MAX_AB : CORE_DELAY;
    localparam int CW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CW-1:0] FILTER_LAST  = CW'(LOCK_FILTER - 1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STAGGER_LAST = CW'(CORE_DELAY - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK,
        FILTER,
        HOLD,
        STAGGER,
        RUN
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_nextCount;

    logic            r_lockedMeta;
    logic            r_lockedSync;

    logic            r_periphReset;
    logic            r_coreResetn;
    logic            r_ready;
    logic            r_lockLost;
    logic [7:0]      r_lossCount;

    logic            w_lockLoss;
    logic            w_runLoss;
    logic            w_periphNext;
    logic            w_runNext;
    logic            w_lostNext;
    logic [7:0]      w_lossCountNext;

    // locked comes from another domain; only the second flop is used downstream
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            r_lockedMeta <= 1'b0;
            r_lockedSync <= 1'b0;
        end else begin
            r_lockedMeta <= locked;
            r_lockedSync <= r_lockedMeta;
        end
    end

    assign w_lockLoss = !r_lockedSync && (r_state != WAIT_LOCK);
    assign w_runLoss  = !r_lockedSync && (r_state == RUN);

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            r_state         <= WAIT_LOCK;
            r_count         <= '0;
            r_periphReset   <= 1'b1;
            r_coreResetn    <= 1'b0;
            r_ready         <= 1'b0;
            r_lockLost      <= 1'b0;
            r_lossCount     <= 8'd0;
        end else begin
            r_state         <= w_nextState;
            r_count         <= w_nextCount;
            r_periphReset   <= w_periphNext;
            r_coreResetn    <= w_runNext;
            r_ready         <= w_runNext;
            r_lockLost      <= w_lostNext;
            r_lossCount     <= w_lossCountNext;
        end
    end

    // Lock loss outranks a soft request; every state change clears the counter
    always_comb begin
        w_nextState = r_state;
        w_nextCount = '0;
        if (w_lockLoss) begin
            w_nextState = WAIT_LOCK;
        end else begin
            case (r_state)
                WAIT_LOCK: begin
                    if (r_lockedSync) begin
                        w_nextState = FILTER;
                    end
                end
                FILTER: begin
                    if (r_count == FILTER_LAST) begin
                        w_nextState = HOLD;
                    end else begin
                        w_nextCount = r_count + 1'b1;
                    end
                end
                HOLD: begin
                    if (r_count == HOLD_LAST) begin
                        w_nextState = STAGGER;
                    end else begin
                        w_nextCount = r_count + 1'b1;
                    end
                end
                STAGGER: begin
                    if (soft_reset_req) begin
                        w_nextState = HOLD;
                    end else if (r_count == STAGGER_LAST) begin
                        w_nextState = RUN;
                    end else begin
                        w_nextCount = r_count + 1'b1;
                    end
                end
                RUN: begin
                    if (soft_reset_req) begin
                        w_nextState = HOLD;
                    end
                end
                default: begin
                    w_nextState = WAIT_LOCK;
                end
            endcase
        end
    end

    always_comb begin
        w_periphNext    = (w_nextState == WAIT_LOCK) || (w_nextState == FILTER) ||
                          (w_nextState == HOLD);
        w_runNext       = (w_nextState == RUN);
        w_lostNext      = r_lockLost;
        w_lossCountNext = r_lossCount;
        if (w_runLoss) begin
            w_lostNext = 1'b1;
            if (r_lossCount != 8'hFF) begin
                w_lossCountNext = r_lossCount + 8'd1;
            end
        end else if (lock_lost_clr) begin
            w_lostNext = 1'b0;
        end
    end

    assign periph_reset    = r_periphReset;
    assign core_resetn     = r_coreResetn;
    assign ready           = r_ready;
    assign lock_lost       = r_lockLost;
    assign lock_loss_count = r_lossCount;

endmodule

// File: doc/clk_reset_seq.md
CLK_RESET_SEQ -- requirements
Module: clk_reset_seq

Interface
REQ-001 The block SHALL have parameter LOCK_FILTER, default 16: consecutive cycles locked must be stable high before sequencing starts.
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 256: cycles periph_reset stays asserted after the lock filter passes.
REQ-003 The block SHALL have parameter CORE_DELAY, default 32: cycles between periph_reset release and core_resetn release.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 sys_clock  input  1  single clock; output of the clock-select stage.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 locked  input  1  asynchronous MMCM lock indication from the clock-select stage.
REQ-008 soft_reset_req  input  1  single-cycle pulse from a host register requesting a re-sequence.
REQ-009 lock_lost_clr  input  1  single-cycle pulse that clears lock_lost.
REQ-010 periph_reset  output  1  active-high reset to the bus and peripherals.
REQ-011 core_resetn  output  1  active-low reset to the Arm core.
REQ-012 ready  output  1  high only in state RUN.
REQ-013 lock_lost  output  1  sticky flag, set on lock loss while in RUN.
REQ-014 lock_loss_count  output  8  saturating count of lock losses seen in RUN.

Function
REQ-015 locked SHALL pass through a 2-flop synchronizer; locked_s is the second flop, and the FSM uses only locked_s.
REQ-016 The FSM SHALL have states WAIT_LOCK, FILTER, HOLD, STAGGER and RUN, sharing one cycle counter sized to the largest parameter.
REQ-017 WAIT_LOCK: counter=0; on locked_s=1 the FSM SHALL go to FILTER.
REQ-018 FILTER: the counter SHALL increment each cycle; at count LOCK_FILTER-1 with locked_s=1 the FSM SHALL go to HOLD and clear the counter.
REQ-019 HOLD: at count HOLD_CYCLES-1 the FSM SHALL go to STAGGER and clear the counter.
REQ-020 STAGGER: at count CORE_DELAY-1 the FSM SHALL go to RUN.
REQ-021 RUN SHALL remain until a lock loss or a soft_reset_req.
REQ-022 Outputs SHALL be registered, decoded from the next state, and change on the same edge as the state: periph_reset=1 in WAIT_LOCK/FILTER/HOLD, else 0.
REQ-023 core_resetn SHALL be 1 only in RUN; ready SHALL be 1 only in RUN.
REQ-024 locked_s=0 in FILTER, HOLD, STAGGER or RUN SHALL force the FSM to WAIT_LOCK on that edge and clear the counter; periph_reset=1 and core_resetn=0 on the same edge.
REQ-025 Lock loss in RUN SHALL set lock_lost and increment lock_loss_count, saturating at 255; lock loss in any other state SHALL update neither.
REQ-026 soft_reset_req in STAGGER or RUN SHALL send the FSM to HOLD with the counter cleared, skipping FILTER; in any other state it SHALL be ignored.
REQ-027 Simultaneous lock loss and soft_reset_req: lock loss SHALL win (WAIT_LOCK).
REQ-028 lock_lost_clr SHALL clear lock_lost on the next edge; if a new loss occurs in the same cycle, set SHALL win; lock_lost_clr SHALL NOT clear lock_loss_count.
REQ-029 With locked held at 1, as in PLL bypass, the full sequence SHALL still run.

Reset
REQ-030 While reset=1 at an edge, the block SHALL set: sync flops=0, state=WAIT_LOCK, counter=0, periph_reset=1, core_resetn=0, ready=0, lock_lost=0, lock_loss_count=0.
REQ-031 Reset asserted mid-sequence or in RUN SHALL take effect on that edge, overriding all other inputs.
REQ-032 After reset deasserts, sequencing SHALL restart from WAIT_LOCK, including the full LOCK_FILTER.

Verification
REQ-033 Defaults; locked rises and is first sampled at edge E -> periph_reset falls at E+274, core_resetn and ready rise at E+306.
REQ-034 Glitch: locked high for 10 cycles, then low 1 cycle, then high -> FSM returns to WAIT_LOCK, the filter restarts, and periph_reset never deasserts early; lock_loss_count stays 0.
REQ-035 In RUN, locked drops -> core_resetn=0 and periph_reset=1 within 3 edges, lock_lost=1, lock_loss_count=1; after 300 lock losses in RUN, lock_loss_count=255.
REQ-036 In RUN, soft_reset_req pulse -> ready=0 next edge, periph_reset=1 for 256 cycles, core_resetn=1 again 288 cycles after the request edge.
REQ-037 Same-cycle lock_lost_clr and lock loss -> lock_lost stays 1; lock_lost_clr alone -> lock_lost=0, count unchanged.
REQ-038 reset asserted during STAGGER -> all outputs at reset values on that edge; after release, the full 306-cycle sequence repeats.
